// File: rtl/axi_tdd_ng_counter.sv
// TDD timing core: sequences IDLE -> ARMED -> WAITING -> RUNNING and drives the frame counter/strobes.
// Define AXI_TDD_NG_SYNC_RESET_EN to let a sync event in RUNNING restart the current frame.
module axi_tdd_ng_counter #(
    parameter int REGISTER_WIDTH    = 32,
    parameter int BURST_COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tdd_enable,
    input  logic                         tdd_sync_en,
    input  logic                         tdd_sync,
    input  logic                         tdd_sync_soft,
    input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
    input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
    input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
    output logic [1:0]                   tdd_cstate,
    output logic [REGISTER_WIDTH-1:0]    tdd_counter,
    output logic                         tdd_frame_start,
    output logic                         tdd_endof_frame
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        WAITING = 2'b10,
        RUNNING = 2'b11
    } state_t;

    state_t                       state;
    state_t                       state_n;
    logic [REGISTER_WIDTH-1:0]    counter_n;
    logic [REGISTER_WIDTH-1:0]    delay_q;
    logic [REGISTER_WIDTH-1:0]    length_q;
    logic [BURST_COUNT_WIDTH-1:0] burst_q;
    logic [BURST_COUNT_WIDTH-1:0] frame_cnt;
    logic [BURST_COUNT_WIDTH-1:0] frame_cnt_n;
    logic [BURST_COUNT_WIDTH-1:0] frame_cnt_inc;
    logic                         enable_q;
    logic                         enable_edge;
    logic                         sync_event;
    logic                         arm;

    assign tdd_cstate = state;

    always_comb begin
        sync_event    = tdd_sync | tdd_sync_soft;
        enable_edge   = tdd_enable & ~enable_q;
        frame_cnt_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + BURST_COUNT_WIDTH'(1);
        state_n       = state;
        counter_n     = tdd_counter;
        frame_cnt_n   = frame_cnt;
        arm           = 1'b0;

        if (!tdd_enable) begin
            state_n     = IDLE;
            counter_n   = '0;
            frame_cnt_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    counter_n   = '0;
                    frame_cnt_n = '0;
                    if (enable_edge) begin
                        state_n = ARMED;
                        arm     = 1'b1;
                    end
                end
                ARMED: begin
                    counter_n = '0;
                    if (!tdd_sync_en || sync_event)
                        state_n = (delay_q != '0) ? WAITING : RUNNING;
                end
                WAITING: begin
                    if (tdd_counter == delay_q - REGISTER_WIDTH'(1)) begin
                        state_n   = RUNNING;
                        counter_n = '0;
                    end else begin
                        counter_n = tdd_counter + REGISTER_WIDTH'(1);
                    end
                end
                RUNNING: begin
                    if (tdd_counter == length_q) begin
                        counter_n   = '0;
                        frame_cnt_n = frame_cnt_inc;
                        if (burst_q != '0 && frame_cnt_inc == burst_q) begin
                            state_n     = IDLE;
                            frame_cnt_n = '0;
                        end
                    end else begin
                        counter_n = tdd_counter + REGISTER_WIDTH'(1);
                    end
`ifdef AXI_TDD_NG_SYNC_RESET_EN
                    // A restart outranks the end-of-burst exit in the same cycle.
                    if (sync_event) begin
                        state_n     = RUNNING;
                        counter_n   = '0;
                        frame_cnt_n = '0;
                    end
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            tdd_counter     <= '0;
            tdd_frame_start <= 1'b0;
            tdd_endof_frame <= 1'b0;
            delay_q         <= '0;
            length_q        <= '0;
            burst_q         <= '0;
            frame_cnt       <= '0;
            enable_q        <= 1'b0;
        end else begin
            enable_q    <= tdd_enable;
            state       <= state_n;
            tdd_counter <= counter_n;
            frame_cnt   <= frame_cnt_n;
            if (arm) begin
                delay_q  <= tdd_startup_delay;
                length_q <= tdd_frame_length;
                burst_q  <= tdd_burst_count;
            end
            // Strobes are derived from next-state values so they line up with the registered counter.
            tdd_frame_start <= (state_n == RUNNING) && (counter_n == '0);
            tdd_endof_frame <= (state_n == RUNNING) && (counter_n == length_q);
        end
    end

endmodule

// File: tb/tb_axi_tdd_ng_counter.sv
// Self-checking bench for axi_tdd_ng_counter: expected per-cycle traces are generated from the frame rules.
module tb_axi_tdd_ng_counter;

    localparam int RW = 32;
    localparam int BW = 32;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ARMED = 2'b01;
    localparam logic [1:0] S_WAIT  = 2'b10;
    localparam logic [1:0] S_RUN   = 2'b11;

    typedef struct packed {
        logic [1:0]    st;
        logic [RW-1:0] cnt;
        logic          fs;
        logic          eof;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          tdd_enable;
    logic          tdd_sync_en;
    logic          tdd_sync;
    logic          tdd_sync_soft;
    logic [BW-1:0] tdd_burst_count;
    logic [RW-1:0] tdd_startup_delay;
    logic [RW-1:0] tdd_frame_length;
    logic [1:0]    tdd_cstate;
    logic [RW-1:0] tdd_counter;
    logic          tdd_frame_start;
    logic          tdd_endof_frame;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    axi_tdd_ng_counter #(
        .REGISTER_WIDTH   (RW),
        .BURST_COUNT_WIDTH(BW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tdd_enable       (tdd_enable),
        .tdd_sync_en      (tdd_sync_en),
        .tdd_sync         (tdd_sync),
        .tdd_sync_soft    (tdd_sync_soft),
        .tdd_burst_count  (tdd_burst_count),
        .tdd_startup_delay(tdd_startup_delay),
        .tdd_frame_length (tdd_frame_length),
        .tdd_cstate       (tdd_cstate),
        .tdd_counter      (tdd_counter),
        .tdd_frame_start  (tdd_frame_start),
        .tdd_endof_frame  (tdd_endof_frame)
    );

    function automatic obs_t mk(logic [1:0] s, int unsigned c, logic f, logic e);
        return {s, RW'(c), f, e};
    endfunction

    function automatic obs_t get_obs();
        return {tdd_cstate, tdd_counter, tdd_frame_start, tdd_endof_frame};
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("st=%0d cnt=%0d fs=%0b eof=%0b", o.st, o.cnt, o.fs, o.eof);
    endfunction

    // Expected trace: ARMED cycles, delay cycles counting 0..d-1, B frames of 0..L, then IDLE.
    task automatic build_trace(input int unsigned arm_cycles, input int unsigned d,
                               input int unsigned len, input int unsigned b,
                               input int unsigned idle_tail);
        exp_q.delete();
        repeat (arm_cycles) exp_q.push_back(mk(S_ARMED, 0, 1'b0, 1'b0));
        for (int unsigned i = 0; i < d; i++) exp_q.push_back(mk(S_WAIT, i, 1'b0, 1'b0));
        for (int unsigned f = 0; f < b; f++)
            for (int unsigned c = 0; c <= len; c++)
                exp_q.push_back(mk(S_RUN, c, c == 0, c == len));
        repeat (idle_tail) exp_q.push_back(mk(S_IDLE, 0, 1'b0, 1'b0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int unsigned d, input int unsigned len,
                           input int unsigned b, input logic se);
        tdd_startup_delay = RW'(d);
        tdd_frame_length  = RW'(len);
        tdd_burst_count   = BW'(b);
        tdd_sync_en       = se;
    endtask

    task automatic go_idle();
        tdd_enable    = 1'b0;
        tdd_sync      = 1'b0;
        tdd_sync_soft = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        obs_t e;
        rst = 1'b1;
        tdd_enable = 1'b1;
        step();
        step();
        e = mk(S_IDLE, 0, 1'b0, 1'b0);
        checks++;
        if (get_obs() !== e) begin
            errors++;
            $display("FAIL reset_held: got %s expected %s", fmt(get_obs()), fmt(e));
        end
        rst = 1'b0;
        tdd_enable = 1'b0;
        step();
        checks++;
        if (get_obs() !== e) begin
            errors++;
            $display("FAIL reset_release: got %s expected %s", fmt(get_obs()), fmt(e));
        end
    endtask

    task automatic test_basic_run();
        set_cfg(3, 4, 2, 1'b0);
        build_trace(1, 3, 4, 2, 5);
        tdd_enable = 1'b1;
        for (int unsigned i = 0; i < exp_q.size(); i++) begin
            step();
            checks++;
            if (get_obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_run[%0d]: got %s expected %s", i, fmt(get_obs()), fmt(exp_q[i]));
            end
        end
        go_idle();
    endtask

    task automatic test_sync_armed();
        obs_t e;
        set_cfg(0, 0, 0, 1'b1);
        tdd_enable = 1'b1;
        e = mk(S_ARMED, 0, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 20; i++) begin
            step();
            checks++;
            if (get_obs() !== e) begin
                errors++;
                $display("FAIL sync_armed_hold[%0d]: got %s expected %s", i, fmt(get_obs()), fmt(e));
            end
        end
        tdd_sync = 1'b1;
        e = mk(S_RUN, 0, 1'b1, 1'b1);
        for (int unsigned i = 0; i < 15; i++) begin
            step();
            tdd_sync = 1'b0;
            checks++;
            if (get_obs() !== e) begin
                errors++;
                $display("FAIL sync_armed_run[%0d]: got %s expected %s", i, fmt(get_obs()), fmt(e));
            end
        end
        tdd_enable = 1'b0;
        step();
        e = mk(S_IDLE, 0, 1'b0, 1'b0);
        checks++;
        if (get_obs() !== e) begin
            errors++;
            $display("FAIL sync_armed_stop: got %s expected %s", fmt(get_obs()), fmt(e));
        end
        go_idle();
    endtask

    task automatic test_abort();
        obs_t e;
        set_cfg(0, 9, 0, 1'b0);
        build_trace(1, 0, 9, 1, 0);
        tdd_enable = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            checks++;
            if (get_obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_run[%0d]: got %s expected %s", i, fmt(get_obs()), fmt(exp_q[i]));
            end
        end
        tdd_enable = 1'b0;
        step();
        e = mk(S_IDLE, 0, 1'b0, 1'b0);
        checks++;
        if (get_obs() !== e) begin
            errors++;
            $display("FAIL abort_idle: got %s expected %s", fmt(get_obs()), fmt(e));
        end
        tdd_enable = 1'b1;
        step();
        e = mk(S_ARMED, 0, 1'b0, 1'b0);
        checks++;
        if (get_obs() !== e) begin
            errors++;
            $display("FAIL abort_rearm: got %s expected %s", fmt(get_obs()), fmt(e));
        end
        step();
        e = mk(S_RUN, 0, 1'b1, 1'b0);
        checks++;
        if (get_obs() !== e) begin
            errors++;
            $display("FAIL abort_rerun: got %s expected %s", fmt(get_obs()), fmt(e));
        end
        go_idle();
    endtask

    task automatic test_shadowing();
        set_cfg(2, 4, 2, 1'b0);
        build_trace(1, 2, 4, 2, 2);
        tdd_enable = 1'b1;
        for (int unsigned i = 0; i < exp_q.size(); i++) begin
            step();
            checks++;
            if (get_obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL shadowing[%0d]: got %s expected %s", i, fmt(get_obs()), fmt(exp_q[i]));
            end
            if (exp_q[i].st == S_WAIT || exp_q[i].st == S_RUN) set_cfg(9, 7, 5, 1'b1);
        end
        go_idle();
    endtask

    task automatic test_sync_reset();
        set_cfg(0, 4, 2, 1'b0);
        build_trace(1, 0, 4, 2, 2);
`ifdef AXI_TDD_NG_SYNC_RESET_EN
        for (int unsigned c = 0; c < 4; c++)
            exp_q.insert(1 + c, mk(S_RUN, c, c == 0, 1'b0));
`endif
        tdd_enable = 1'b1;
        for (int unsigned i = 0; i < exp_q.size(); i++) begin
            step();
            checks++;
            if (get_obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL sync_reset[%0d]: got %s expected %s", i, fmt(get_obs()), fmt(exp_q[i]));
            end
            tdd_sync_soft = (i == 4);
        end
        go_idle();
    endtask

    task automatic test_random_bursts();
        int unsigned d, len, b, k, arm_cycles;
        logic        se;
        for (int unsigned it = 0; it < 10; it++) begin
            d   = $urandom_range(0, 5);
            len = $urandom_range(0, 6);
            b   = $urandom_range(1, 3);
            k   = $urandom_range(0, 4);
            se  = 1'($urandom_range(0, 1));
            arm_cycles = se ? k + 1 : 1;
            set_cfg(d, len, b, se);
            build_trace(arm_cycles, d, len, b, 2);
            tdd_enable = 1'b1;
            for (int unsigned i = 0; i < exp_q.size(); i++) begin
                step();
                checks++;
                if (get_obs() !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random%0d[%0d] d=%0d len=%0d b=%0d se=%0b: got %s expected %s",
                             it, i, d, len, b, se, fmt(get_obs()), fmt(exp_q[i]));
                end
                tdd_sync      = 1'b0;
                tdd_sync_soft = 1'b0;
                if (exp_q[i].st == S_ARMED && se && i == arm_cycles - 1) begin
                    if ($urandom_range(0, 1) == 0) tdd_sync = 1'b1;
                    else                           tdd_sync_soft = 1'b1;
                end else if (exp_q[i].st == S_WAIT || (exp_q[i].st == S_ARMED && !se)) begin
                    tdd_sync      = 1'($urandom_range(0, 1));
                    tdd_sync_soft = 1'($urandom_range(0, 1));
                end
            end
            go_idle();
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t e;
        set_cfg(6, 3, 1, 1'b0);
        build_trace(1, 6, 3, 1, 0);
        tdd_enable = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            checks++;
            if (get_obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_mid_pre[%0d]: got %s expected %s", i, fmt(get_obs()), fmt(exp_q[i]));
            end
        end
        rst = 1'b1;
        step();
        e = mk(S_IDLE, 0, 1'b0, 1'b0);
        checks++;
        if (get_obs() !== e) begin
            errors++;
            $display("FAIL rst_mid_reset: got %s expected %s", fmt(get_obs()), fmt(e));
        end
        rst = 1'b0;
        tdd_enable = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            step();
            checks++;
            if (get_obs() !== e) begin
                errors++;
                $display("FAIL rst_mid_idle[%0d]: got %s expected %s", i, fmt(get_obs()), fmt(e));
            end
        end
        tdd_enable = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            checks++;
            if (get_obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_mid_rearm[%0d]: got %s expected %s", i, fmt(get_obs()), fmt(exp_q[i]));
            end
        end
        go_idle();
    endtask

    initial begin
        rst           = 1'b1;
        tdd_enable    = 1'b0;
        tdd_sync_en   = 1'b0;
        tdd_sync      = 1'b0;
        tdd_sync_soft = 1'b0;
        set_cfg(0, 0, 0, 1'b0);
        test_reset();
        test_basic_run();
        test_sync_armed();
        test_abort();
        test_shadowing();
        test_sync_reset();
        test_random_bursts();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_tdd_ng_counter.md
# axi_tdd_ng_counter

Timing core of the TDD controller. It sequences the frame counter through the IDLE, ARMED, WAITING and RUNNING states: it arms on enable, optionally waits for a sync event, applies a startup delay, then runs a programmed number of frames. It sits between the register map, which supplies the control, burst, delay and frame-length values, and the per-channel on/off comparators. Those comparators consume `tdd_counter` and the frame strobes.

## Interface
- `REGISTER_WIDTH`, default 32: width of the startup-delay, frame-length and counter values.
- `BURST_COUNT_WIDTH`, default 32: width of the burst count.
- `clk`  in  1  the only clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tdd_enable`  in  1  control enable (level).
- `tdd_sync_en`  in  1  when 1, ARMED waits for a sync event.
- `tdd_sync`  in  1  external sync pulse, already synchronous to `clk`.
- `tdd_sync_soft`  in  1  software sync pulse.
- `tdd_burst_count`  in  BURST_COUNT_WIDTH  number of frames to run; 0 means run indefinitely.
- `tdd_startup_delay`  in  REGISTER_WIDTH  cycles spent in WAITING.
- `tdd_frame_length`  in  REGISTER_WIDTH  last counter value of a frame; a frame lasts length+1 cycles.
- `tdd_cstate`  out  2  current state: IDLE=00, ARMED=01, WAITING=10, RUNNING=11.
- `tdd_counter`  out  REGISTER_WIDTH  delay or frame counter.
- `tdd_frame_start`  out  1  high on the first cycle of every RUNNING frame.
- `tdd_endof_frame`  out  1  high when RUNNING and `tdd_counter` equals the latched frame length.

## Operation
- Sync event = `tdd_sync | tdd_sync_soft`.
- Enable edge = `tdd_enable` high while its 1-cycle registered copy is low.
- Config latch: delay, frame length and burst count are captured into shadow registers on the IDLE→ARMED transition. Input changes are ignored outside IDLE.
- Priority order in every state:
  - `rst`
  - `tdd_enable`=0, which forces IDLE and counter 0
  - state rules below
- IDLE: counter held at 0. An enable edge moves to ARMED.
- ARMED: counter held at 0.
  - Leaves ARMED when `tdd_sync_en`=0, or when a sync event occurs.
  - Goes to WAITING if latched delay ≠ 0, otherwise directly to RUNNING.
  - A sync event while `tdd_sync_en`=0 has no extra effect.
- WAITING: counter increments from 0. When counter = delay−1, next state is RUNNING with counter 0.
- RUNNING:
  - Counter increments.
  - At counter = frame_length it wraps to 0 and the internal frame count increments.
  - Burst ≠ 0 and the completed frame count reaches burst: next state is IDLE with counter 0.
  - Burst = 0: runs until `tdd_enable` falls.
  - The internal frame count is BURST_COUNT_WIDTH wide and saturates rather than wrapping (irrelevant when burst=0).
- Returning to IDLE after a finished burst needs a fresh enable edge. A level-high `tdd_enable` does not re-arm.
- Frame length 0: 1-cycle frames, with `tdd_frame_start` and `tdd_endof_frame` both high every RUNNING cycle.
- Sync events in WAITING are ignored.
- Sync events in RUNNING are ignored unless the macro in Configuration is defined.

## Timing
- All outputs are registered. A state change and its counter value appear one cycle after the qualifying input.
- Reset values: `tdd_cstate`=IDLE, `tdd_counter`=0, `tdd_frame_start`=0, `tdd_endof_frame`=0, shadow registers 0, frame count 0, registered enable 0.
- Enable edge to ARMED: 1 cycle.
- With `tdd_sync_en`=0: ARMED lasts exactly 1 cycle.
- With sync: the sync pulse in cycle N gives WAITING or RUNNING at N+1.
- WAITING lasts exactly `tdd_startup_delay` cycles.
- The first RUNNING cycle has counter 0 and `tdd_frame_start`=1.
- A burst of B frames with length L occupies exactly B·(L+1) RUNNING cycles. IDLE follows on the cycle after the last `tdd_endof_frame`.
- `tdd_enable` low in cycle N gives IDLE and counter 0 at N+1 from any state, with no partial-frame completion.

## Configuration
- Macro: `AXI_TDD_NG_SYNC_RESET_EN`.
- Defined: a sync event in RUNNING restarts the frame.
  - Counter goes to 0, the frame count clears, and `tdd_frame_start` is 1 next cycle.
  - The state stays RUNNING; latched values are unchanged.
  - A sync coinciding with the burst's final `tdd_endof_frame` wins: the block stays in RUNNING and does not go to IDLE.
- Not defined: sync events in RUNNING are ignored. The sync logic collapses to the ARMED exit only.

## Test plan
- Basic run:
  - Stimulus: reset, then delay=3, length=4, burst=2, sync_en=0, enable rises.
  - Response: ARMED for 1 cycle, WAITING for 3 cycles with counter 0,1,2, RUNNING for 10 cycles with counter 0..4 twice, two endof_frame pulses, then IDLE.
- Sync-armed:
  - Stimulus: sync_en=1, delay=0, length=0, burst=0; enable rises; `tdd_sync` pulses 20 cycles later.
  - Response: ARMED holds for 20 cycles, then RUNNING with frame_start and endof_frame high every cycle, until enable drops.
- Abort:
  - Stimulus: enable falls mid-frame at counter=2, with length=9.
  - Response: IDLE and counter 0 on the next cycle. Re-raising enable re-arms; a level-high enable after a finished burst does not.
- Shadowing:
  - Stimulus: change `tdd_frame_length` from 4 to 7 during RUNNING.
  - Response: the frame still wraps at 4.
- Sync reset (macro defined):
  - Stimulus: soft sync at counter=3 of frame 1 with burst=2, length=4.
  - Response: counter returns to 0, and 2 further full frames run before IDLE.
  - Without the macro: the sync is ignored and the total is 10 RUNNING cycles.
- Reset mid-run:
  - Stimulus: `rst` asserted during WAITING.
  - Response: all outputs at reset values on the next cycle, and a subsequent enable edge is required to re-arm.
